// File: rtl/coin_acceptor_if.sv
// Coin acceptor signal bundle.
//   master : drives raw_Coin, raw_Cancel, state; observes the conditioned outputs
//   slave  : the coin_acceptor itself
//   raw_Coin/raw_Cancel : asynchronous slot sensor / cancel button
//   state               : current washing-machine controller state
//   sig_Coin/sig_Cancel : one-cycle pulses to the controller
//   coin_Reject/coin_Refund : one-cycle pulses to the coin mechanism
//   credit              : coins currently held
interface coin_acceptor_if #(
  parameter int CREDIT_WIDTH = 2
);
  logic                    raw_Coin;
  logic                    raw_Cancel;
  logic [2:0]              state;
  logic                    sig_Coin;
  logic                    sig_Cancel;
  logic                    coin_Reject;
  logic                    coin_Refund;
  logic [CREDIT_WIDTH-1:0] credit;

  modport master (
    output raw_Coin, raw_Cancel, state,
    input  sig_Coin, sig_Cancel, coin_Reject, coin_Refund, credit
  );

  modport slave (
    input  raw_Coin, raw_Cancel, state,
    output sig_Coin, sig_Cancel, coin_Reject, coin_Refund, credit
  );
endinterface

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: synchronises and debounces the coin-slot and
// cancel inputs, accumulates credit up to PRICE, issues sig_Coin when paid,
// forwards cancels, and refunds partial credit one coin every other cycle.
// Ports:
//   clock : system clock (rising edge)
//   reset : asynchronous active-high reset
//   io    : coin_acceptor_if slave modport (raw inputs, controller state,
//           registered one-cycle output pulses and credit count)
module coin_acceptor #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         PRICE           = 3,
  parameter int         CREDIT_WIDTH    = 2,
  parameter logic [2:0] IDLE_STATE      = 3'b000
) (
  input logic             clock,
  input logic             reset,
  coin_acceptor_if.slave  io
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [CREDIT_WIDTH-1:0] PRICE_M1 = CREDIT_WIDTH'(PRICE - 1);
  localparam logic [CREDIT_WIDTH-1:0] CR_ONE   = CREDIT_WIDTH'(1);

  typedef enum logic [1:0] {COLLECT, PAID, REFUND} st_t;

  // Index 0: coin slot, index 1: cancel button.
  logic [1:0]       raw;
  logic [1:0]       sync1, sync2, level, ev;
  logic [CNT_W-1:0] db_cnt [2];
  logic             coin_ev, cancel_ev;

  st_t                     st, st_n;
  logic [CREDIT_WIDTH-1:0] credit, credit_n;
  logic                    refund_wait, refund_wait_n;
  logic                    coin_q, cancel_q, reject_q, refund_q;
  logic                    coin_n, cancel_n, reject_n, refund_n;

  assign raw       = {io.raw_Cancel, io.raw_Coin};
  assign coin_ev   = ev[0];
  assign cancel_ev = ev[1];

  // Debounce: the level flips after DEBOUNCE_CYCLES consecutive mismatching
  // samples; ev is registered on the same edge so it marks a 0->1 flip.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      ev    <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        ev[i] <= 1'b0;
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            level[i]  <= sync2[i];
            ev[i]     <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CNT_ONE;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= COLLECT;
      credit      <= '0;
      refund_wait <= 1'b0;
      coin_q      <= 1'b0;
      cancel_q    <= 1'b0;
      reject_q    <= 1'b0;
      refund_q    <= 1'b0;
    end else begin
      st          <= st_n;
      credit      <= credit_n;
      refund_wait <= refund_wait_n;
      coin_q      <= coin_n;
      cancel_q    <= cancel_n;
      reject_q    <= reject_n;
      refund_q    <= refund_n;
    end
  end

  always_comb begin
    st_n          = st;
    credit_n      = credit;
    refund_wait_n = refund_wait;
    coin_n        = 1'b0;
    cancel_n      = 1'b0;
    reject_n      = 1'b0;
    refund_n      = 1'b0;
    case (st)
      COLLECT: begin
        // A cancel wins over a simultaneous coin; the coin goes to the chute
        // and the cancel acts on the credit held before this cycle.
        if (cancel_ev) begin
          reject_n = coin_ev;
          if (credit != '0) begin
            st_n          = REFUND;
            refund_wait_n = 1'b0;
          end else begin
            cancel_n = 1'b1;
          end
        end else if (coin_ev) begin
          if (io.state == IDLE_STATE) begin
            if (credit == PRICE_M1) begin
              coin_n   = 1'b1;
              credit_n = '0;
              st_n     = PAID;
            end else begin
              credit_n = credit + CR_ONE;
            end
          end else begin
            reject_n = 1'b1;
          end
        end
      end
      PAID: begin
        reject_n = coin_ev;
        cancel_n = cancel_ev;
        if (io.state != IDLE_STATE) st_n = COLLECT;
      end
      REFUND: begin
        reject_n = coin_ev;
        if (refund_wait) begin
          refund_wait_n = 1'b0;
        end else if (credit != '0) begin
          refund_n      = 1'b1;
          credit_n      = credit - CR_ONE;
          refund_wait_n = 1'b1;
          if (credit == CR_ONE) st_n = COLLECT;
        end else begin
          st_n = COLLECT;
        end
      end
      default: st_n = COLLECT;
    endcase
  end

  assign io.sig_Coin    = coin_q;
  assign io.sig_Cancel  = cancel_q;
  assign io.coin_Reject = reject_q;
  assign io.coin_Refund = refund_q;
  assign io.credit      = credit;

endmodule
